exe_mem_req_unit: RTL
=====================

Name: exe_mem_req_unit

Overview:
- Parametrised data-memory request unit for the EXE stage. Successor to the single-request, 32-bit-only store/load issue logic.
- Accepts one memory op per handshake from EXE and drives the SRAM-like data bus (req/addr_ok/data_ok).
- Tracks up to MAX_OUTST in-flight requests in order, discards responses of flushed requests, and returns aligned, extended load data to MEM.
- Supports 32- or 64-bit data buses and raises an alignment exception (ALE) instead of issuing a misaligned access.

Parameters:
DATA_W, 32, data bus width; legal values 32 or 64.
MAX_OUTST, 2, max accepted-but-unanswered requests; legal range 1..8.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  EXE has a memory op
in_ready  out  1  unit accepts the op this cycle
in_we  in  1  1=store, 0=load
in_size  in  2  0=byte, 1=half, 2=word, 3=dword
in_unsigned  in  1  zero-extend load (ld.bu/ld.hu)
in_addr  in  32  byte address
in_wdata  in  DATA_W  store data in low bytes
in_dest  in  5  load destination register
flush  in  1  exception/ertn flush, one cycle
data_sram_req  out  1  request valid
data_sram_wr  out  1  write request
data_sram_size  out  2  copy of in_size
data_sram_addr  out  32  address
data_sram_wstrb  out  DATA_W/8  byte enables
data_sram_wdata  out  DATA_W  lane-replicated store data
data_sram_addr_ok  in  1  request accepted
data_sram_data_ok  in  1  response, in request order
data_sram_rdata  in  DATA_W  read data
resp_valid  out  1  one-cycle completion pulse for a non-cancelled request
resp_is_load  out  1  completion belongs to a load
resp_dest  out  5  destination of the completing load
resp_rdata  out  DATA_W  shifted and extended load data
exc_ale  out  1  one-cycle pulse: misaligned access rejected
exc_badv  out  32  faulting address, valid with exc_ale
outst_cnt  out  4  number of requests in flight

Behaviour:
- Reset values: data_sram_req=0, resp_valid=0, exc_ale=0, exc_badv=0, outst_cnt=0. All FIFO entries are invalid after reset.
- in_ready = !req_r && !flush.
- Accept condition: in_valid && in_ready. It updates state on the next edge.
- Alignment check: OFF = log2(DATA_W/8). The address is misaligned when addr[size-1:0] != 0.
- Illegal size: size=3 with DATA_W=32 is treated the same as a misaligned access.
- Misaligned or illegal accept: no request is issued. Next cycle exc_ale=1 and exc_badv=in_addr, for exactly one cycle.
- Aligned accept: latch the payload into req_r; req_r=1 next cycle.
- data_sram_req = req_r && (outst_cnt < MAX_OUTST).
- Once data_sram_req is asserted, it and its payload stay stable until addr_ok, including across flush. Bus rule: no withdrawal.
- wstrb = store ? (((1<<(1<<size))-1) << addr[OFF-1:0]) : 0.
- wdata = the low 2^size bytes of in_wdata replicated across the bus.
- data_sram_wr = store.
- Address handshake (req && addr_ok):
  - clear req_r;
  - push {is_load, size, unsigned, addr[OFF-1:0], dest, cancelled} to the tracking FIFO;
  - outst_cnt++.
- Response (data_ok):
  - pop the FIFO head; outst_cnt--;
  - if the head is not cancelled: same cycle resp_valid=1 (combinational from data_ok);
  - resp_rdata = rdata >> (8*offset), then sign- or zero-extended from 2^size bytes to DATA_W.
  - Stores also complete with resp_is_load=0 and resp_rdata=0.
  - data_ok with an empty FIFO is a bus protocol error and is ignored.
- Simultaneous push and pop in one cycle: outst_cnt is unchanged and both actions apply.
- Flush:
  - every valid FIFO entry gets cancelled=1;
  - a pending req_r is marked cancel_pend, and its entry is pushed with cancelled=1 when addr_ok arrives;
  - in_valid is ignored in the flush cycle;
  - a new accept is allowed from the next cycle, and its responses follow the cancelled ones in order.
- Flush in the same cycle as addr_ok: the pushed entry is cancelled.
- Flush in the same cycle as data_ok: the popped entry's resp_valid is suppressed.
- Full: with outst_cnt == MAX_OUTST, data_sram_req stays low (req_r held). It is raised in the cycle after a data_ok frees an entry.
- Reset mid-operation: all state is cleared. Late data_ok returned after reset is the bus owner's responsibility.

Test Plan:
1. DATA_W=32, store byte at 0x1003 with wdata=0xAB:
   - data_sram_wstrb=4'b1000, wdata=0xABABABAB, wr=1;
   - addr_ok at cycle 2, data_ok at cycle 4 -> resp_valid with resp_is_load=0.
2. DATA_W=32, ld.h signed at 0x2002, rdata=0x8001_xxxx:
   - resp_rdata=0xFFFF8001.
   - Same access with in_unsigned=1 -> resp_rdata=0x00008001.
3. ld.w at 0x3001:
   - no data_sram_req ever;
   - exc_ale pulses for one cycle with exc_badv=0x3001;
   - in_ready=1 the following cycle.
4. MAX_OUTST=2, three back-to-back loads, data_ok withheld:
   - two addr_ok handshakes, outst_cnt=2, third req stays low;
   - first data_ok -> third req rises the next cycle; final outst_cnt=2.
5. Two loads in flight plus a third req pending without addr_ok; flush pulses:
   - req stays high until addr_ok;
   - the three data_ok responses produce no resp_valid;
   - a load accepted after the flush returns resp_valid.
6. DATA_W=64, ld.d at 0x4008 -> resp_rdata = full rdata, and 0x4004 -> exc_ale=1 with exc_badv=0x4004. ld.b at 0x4005, rdata byte 5 = 0x7F -> resp_rdata=0x7F.

Source files
------------

// File: rtl/exe_mem_req_unit_if.sv
// SRAM-like data bus between the EXE memory request unit and the data memory.
// Master issues req/addr, slave answers addr_ok and later data_ok in request order.
interface exe_mem_req_unit_if #(
  parameter int DATA_W = 32
);
  logic                  data_sram_req;
  logic                  data_sram_wr;
  logic [1:0]            data_sram_size;
  logic [31:0]           data_sram_addr;
  logic [DATA_W/8-1:0]   data_sram_wstrb;
  logic [DATA_W-1:0]     data_sram_wdata;
  logic                  data_sram_addr_ok;
  logic                  data_sram_data_ok;
  logic [DATA_W-1:0]     data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/exe_mem_req_unit.sv
// EXE-stage data memory request unit: issues aligned loads/stores on the SRAM bus,
// tracks in-flight requests in order, drops flushed responses, aligns/extends load data.
module exe_mem_req_unit #(
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [31:0]       in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_dest,
  input  logic              flush,
  exe_mem_req_unit_if.master sram,
  output logic              resp_valid,
  output logic              resp_is_load,
  output logic [4:0]        resp_dest,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              exc_ale,
  output logic [31:0]       exc_badv,
  output logic [3:0]        outst_cnt,
  output logic              dbg_req_state
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [3:0]    MAX_CNT  = 4'(MAX_OUTST);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTST - 1);

  typedef enum logic {REQ_IDLE = 1'b0, REQ_PEND = 1'b1} req_state_t;
  req_state_t state_q, state_d;

  // Handshakes: EXE op transfers on in_valid && in_ready; a bus request transfers
  // on data_sram_req && data_sram_addr_ok and is never withdrawn before that.
  logic              req_r, misaligned, accept, issue, push, pop, bus_req;
  logic              we_q, uns_q, cancel_pend_q;
  logic [1:0]        size_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [4:0]        dest_q;
  logic              ale_q;
  logic [31:0]       badv_q;
  logic [3:0]        cnt_q;
  logic [PW-1:0]     wr_ptr, rd_ptr;

  logic              fifo_load [MAX_OUTST];
  logic [1:0]        fifo_size [MAX_OUTST];
  logic              fifo_uns  [MAX_OUTST];
  logic [OFF-1:0]    fifo_off  [MAX_OUTST];
  logic [4:0]        fifo_dest [MAX_OUTST];
  logic              fifo_canc [MAX_OUTST];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign req_r         = (state_q == REQ_PEND);
  assign dbg_req_state = req_r;
  assign in_ready      = !req_r && !flush;
  assign accept        = in_valid && in_ready;
  assign issue         = accept && !misaligned;
  assign bus_req       = req_r && (cnt_q < MAX_CNT);
  assign push          = bus_req && sram.data_sram_addr_ok;
  assign pop           = sram.data_sram_data_ok && (cnt_q != 4'd0);

  // Dword accesses do not exist on a 32-bit bus, so they fault like a misalignment.
  always_comb begin
    misaligned = 1'b0;
    case (in_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = in_addr[0];
      2'd2:    misaligned = |in_addr[1:0];
      default: misaligned = (DATA_W == 32) || (|in_addr[2:0]);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= REQ_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ_IDLE: if (issue) state_d = REQ_PEND;
      REQ_PEND: if (push)  state_d = REQ_IDLE;
      default:             state_d = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'd0;
      addr_q        <= 32'd0;
      wdata_q       <= '0;
      dest_q        <= 5'd0;
      cancel_pend_q <= 1'b0;
      ale_q         <= 1'b0;
      badv_q        <= 32'd0;
    end else begin
      ale_q <= accept && misaligned;
      if (accept && misaligned) badv_q <= in_addr;
      if (issue) begin
        we_q    <= in_we;
        uns_q   <= in_unsigned;
        size_q  <= in_size;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        dest_q  <= in_dest;
      end
      if (push)                cancel_pend_q <= 1'b0;
      else if (flush && req_r) cancel_pend_q <= 1'b1;
      else if (issue)          cancel_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= 4'd0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 4'd1;
        2'b01:   cnt_q <= cnt_q - 4'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Cancelling every slot is harmless: empty slots are rewritten when pushed.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < MAX_OUTST; i++) fifo_canc[i] <= 1'b1;
    end
    if (push) begin
      fifo_load[wr_ptr] <= !we_q;
      fifo_size[wr_ptr] <= size_q;
      fifo_uns[wr_ptr]  <= uns_q;
      fifo_off[wr_ptr]  <= addr_q[OFF-1:0];
      fifo_dest[wr_ptr] <= dest_q;
      fifo_canc[wr_ptr] <= cancel_pend_q || flush;
    end
  end

  always_comb begin
    logic [4:0]  nbytes;
    logic [15:0] strb_full;
    int          lanes;
    nbytes    = 5'd1 << size_q;
    strb_full = ((16'h1 << nbytes) - 16'h1) << addr_q[OFF-1:0];
    lanes     = 1 << size_q;
    sram.data_sram_req   = bus_req;
    sram.data_sram_wr    = we_q;
    sram.data_sram_size  = size_q;
    sram.data_sram_addr  = addr_q;
    sram.data_sram_wstrb = we_q ? strb_full[NB-1:0] : '0;
    sram.data_sram_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      sram.data_sram_wdata[8*i +: 8] = wdata_q[8*(i % lanes) +: 8];
    end
  end

  always_comb begin
    logic [DATA_W-1:0] shifted;
    logic              fill;
    shifted = sram.data_sram_rdata >> {fifo_off[rd_ptr], 3'b000};
    case (fifo_size[rd_ptr])
      2'd0:    fill = shifted[7];
      2'd1:    fill = shifted[15];
      2'd2:    fill = shifted[31];
      default: fill = shifted[DATA_W-1];
    endcase
    if (fifo_uns[rd_ptr]) fill = 1'b0;
    resp_rdata = shifted;
    for (int b = 0; b < DATA_W; b++) begin
      if (b >= (8 << fifo_size[rd_ptr])) resp_rdata[b] = fill;
    end
    if (!fifo_load[rd_ptr]) resp_rdata = '0;
  end

  assign resp_valid   = pop && !fifo_canc[rd_ptr] && !flush;
  assign resp_is_load = fifo_load[rd_ptr];
  assign resp_dest    = fifo_dest[rd_ptr];
  assign exc_ale      = ale_q;
  assign exc_badv     = badv_q;
  assign outst_cnt    = cnt_q;
endmodule
